// File: rtl/cvp14_pkg.sv
// Shared sizing constants and ALU opcode encodings for the CVP14 datapath.
package cvp14_pkg;

  localparam int unsigned NREGS  = 8;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANES  = 16;

  typedef enum logic [3:0] {
    OpVadd = 4'h0,
    OpVdot = 4'h1,
    OpSmul = 4'h2,
    OpSst  = 4'h3,
    OpVld  = 4'h4,
    OpVst  = 4'h5,
    OpSll  = 4'h6,
    OpSlh  = 4'h7,
    OpNop  = 4'hF
  } opcode_e;

endpackage

// File: rtl/cvp14_regfile.sv
// Two-read, one-write register file with asynchronous clear and no write bypass.
module cvp14_regfile #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic [$clog2(Depth)-1:0] rd_addr1_i,
  input  logic [$clog2(Depth)-1:0] rd_addr2_i,
  output logic [Width-1:0]         rd_data1_o,
  output logic [Width-1:0]         rd_data2_o
);

  logic [Width-1:0] regs_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Reads see stored contents only; a same-cycle write shows up after the edge.
  assign rd_data1_o = regs_q[rd_addr1_i];
  assign rd_data2_o = regs_q[rd_addr2_i];

endmodule

// File: rtl/cvp14_datapath.sv
// CVP14 datapath: vector and scalar register files plus a zero-latency lane ALU.
module cvp14_datapath #(
  parameter int unsigned NREGS  = cvp14_pkg::NREGS,
  parameter int unsigned LANE_W = cvp14_pkg::LANE_W,
  parameter int unsigned LANES  = cvp14_pkg::LANES
) (
  input  logic                      Clk1,
  input  logic                      Reset,
  input  logic [$clog2(NREGS)-1:0]  rd_addr_1,
  input  logic [$clog2(NREGS)-1:0]  rd_addr_2,
  input  logic [$clog2(NREGS)-1:0]  wr_dst,
  input  logic                      v_wr_en,
  input  logic [LANES*LANE_W-1:0]   v_wr_data,
  input  logic                      s_wr_en,
  input  logic [LANE_W-1:0]         s_wr_data,
  output logic [LANES*LANE_W-1:0]   v_data_1,
  output logic [LANES*LANE_W-1:0]   v_data_2,
  output logic [LANE_W-1:0]         s_data_1,
  output logic [LANE_W-1:0]         s_data_2,
  input  logic [LANES*LANE_W-1:0]   op_1,
  input  logic [LANES*LANE_W-1:0]   op_2,
  input  logic [3:0]                opcode,
  output logic [LANES*LANE_W-1:0]   result
);

  import cvp14_pkg::*;

  localparam int unsigned Half = LANE_W / 2;

  cvp14_regfile #(
    .Depth(NREGS),
    .Width(LANES * LANE_W)
  ) u_vreg (
    .clk_i     (Clk1),
    .rst_ni    (Reset),
    .wr_en_i   (v_wr_en),
    .wr_addr_i (wr_dst),
    .wr_data_i (v_wr_data),
    .rd_addr1_i(rd_addr_1),
    .rd_addr2_i(rd_addr_2),
    .rd_data1_o(v_data_1),
    .rd_data2_o(v_data_2)
  );

  cvp14_regfile #(
    .Depth(NREGS),
    .Width(LANE_W)
  ) u_sreg (
    .clk_i     (Clk1),
    .rst_ni    (Reset),
    .wr_en_i   (s_wr_en),
    .wr_addr_i (wr_dst),
    .wr_data_i (s_wr_data),
    .rd_addr1_i(rd_addr_1),
    .rd_addr2_i(rd_addr_2),
    .rd_data1_o(s_data_1),
    .rd_data2_o(s_data_2)
  );

  logic [LANE_W-1:0] dot_acc;

  // All lane arithmetic is LANE_W wide, so sums and products wrap modulo 2^LANE_W.
  always_comb begin
    result  = '0;
    dot_acc = '0;
    case (opcode)
      OpVadd: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          result[i*LANE_W +: LANE_W] = op_1[i*LANE_W +: LANE_W] + op_2[i*LANE_W +: LANE_W];
        end
      end
      OpVdot: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          dot_acc = dot_acc + op_1[i*LANE_W +: LANE_W] * op_2[i*LANE_W +: LANE_W];
        end
        result[LANE_W-1:0] = dot_acc;
      end
      OpSmul: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          result[i*LANE_W +: LANE_W] = op_1[LANE_W-1:0] * op_2[i*LANE_W +: LANE_W];
        end
      end
      OpSst, OpVld, OpVst: begin
        result[LANE_W-1:0] = op_1[LANE_W-1:0] + op_2[LANE_W-1:0];
      end
      OpSll: result[LANE_W-1:0] = {op_1[LANE_W-1:Half], op_2[Half-1:0]};
      OpSlh: result[LANE_W-1:0] = {op_2[Half-1:0], op_1[Half-1:0]};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cvp14_datapath.sv
// Self-checking bench for cvp14_datapath: directed cases plus randomized traffic vs a model.
module tb_cvp14_datapath;

  logic         Clk1 = 1'b0;
  logic         Reset = 1'b0;
  logic [2:0]   rd_addr_1 = '0, rd_addr_2 = '0, wr_dst = '0;
  logic         v_wr_en = 1'b0, s_wr_en = 1'b0;
  logic [255:0] v_wr_data = '0;
  logic [15:0]  s_wr_data = '0;
  logic [255:0] v_data_1, v_data_2;
  logic [15:0]  s_data_1, s_data_2;
  logic [255:0] op_1 = '0, op_2 = '0;
  logic [3:0]   opcode = 4'hF;
  logic [255:0] result;

  int checks = 0;
  int errors = 0;

  logic [255:0] vmod [8];
  logic [15:0]  smod [8];

  cvp14_datapath dut (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .wr_dst   (wr_dst),
    .v_wr_en  (v_wr_en),
    .v_wr_data(v_wr_data),
    .s_wr_en  (s_wr_en),
    .s_wr_data(s_wr_data),
    .v_data_1 (v_data_1),
    .v_data_2 (v_data_2),
    .s_data_1 (s_data_1),
    .s_data_2 (s_data_2),
    .op_1     (op_1),
    .op_2     (op_2),
    .opcode   (opcode),
    .result   (result)
  );

  always #5 Clk1 = ~Clk1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reads(input string tag);
    chk({tag, " v1"}, v_data_1, vmod[rd_addr_1]);
    chk({tag, " v2"}, v_data_2, vmod[rd_addr_2]);
    chk({tag, " s1"}, {240'd0, s_data_1}, {240'd0, smod[rd_addr_1]});
    chk({tag, " s2"}, {240'd0, s_data_2}, {240'd0, smod[rd_addr_2]});
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      vmod[i] = '0;
      smod[i] = '0;
    end
  endtask

  // Lane-by-lane arithmetic on plain integers, reduced modulo 65536.
  function automatic logic [255:0] ref_alu(input logic [3:0] opc, input logic [255:0] a,
                                           input logic [255:0] b);
    logic [255:0] r;
    longint unsigned x, y, sum;
    r = '0;
    sum = 0;
    case (opc)
      4'd0, 4'd1, 4'd2: begin
        for (int i = 0; i < 16; i++) begin
          x = longint'(a[16*i +: 16]);
          y = longint'(b[16*i +: 16]);
          if (opc == 4'd0) r[16*i +: 16] = 16'((x + y) % 65536);
          if (opc == 4'd1) sum = sum + (x * y) % 65536;
          if (opc == 4'd2) r[16*i +: 16] = 16'((longint'(a[15:0]) * y) % 65536);
        end
        if (opc == 4'd1) r[15:0] = 16'(sum % 65536);
      end
      4'd3, 4'd4, 4'd5: r[15:0] = 16'((longint'(a[15:0]) + longint'(b[15:0])) % 65536);
      4'd6: r[15:0] = 16'(longint'(a[15:8]) * 256 + longint'(b[7:0]));
      4'd7: r[15:0] = 16'(longint'(b[7:0]) * 256 + longint'(a[7:0]));
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] vexp;
    logic [255:0] lanes;
    clear_model();

    // Reads during reset and after release.
    #2;
    for (int a = 0; a < 8; a++) begin
      rd_addr_1 = 3'(a);
      rd_addr_2 = 3'(7 - a);
      #1;
      chk($sformatf("rst_hold a%0d", a), {v_data_1[255:16], s_data_1}, '0);
    end
    @(negedge Clk1);
    Reset = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_addr_1 = 3'(a);
      rd_addr_2 = 3'(a);
      #1;
      chk_reads($sformatf("rst_rel a%0d", a));
    end

    // Simultaneous vector and scalar write to address 3.
    @(negedge Clk1);
    vexp = '0;
    for (int i = 0; i < 16; i++) vexp[16*i +: 16] = 16'(i);
    wr_dst = 3'd3; v_wr_en = 1'b1; v_wr_data = vexp; s_wr_en = 1'b1; s_wr_data = 16'hBEEF;
    rd_addr_1 = 3'd3; rd_addr_2 = 3'd3;
    #1;
    chk("pre_edge v1", v_data_1, '0);
    chk("pre_edge s2", {240'd0, s_data_2}, '0);
    @(posedge Clk1); #1;
    vmod[3] = vexp; smod[3] = 16'hBEEF;
    v_wr_en = 1'b0; s_wr_en = 1'b0;
    chk("wr3 v1", v_data_1, vexp);
    chk("wr3 s2", {240'd0, s_data_2}, 256'h0000_BEEF);

    // Directed ALU points.
    opcode = 4'h0;
    for (int i = 0; i < 16; i++) begin op_1[16*i +: 16] = 16'hFFFF; op_2[16*i +: 16] = 16'h2; end
    #1;
    lanes = '0;
    for (int i = 0; i < 16; i++) lanes[16*i +: 16] = 16'h0001;
    chk("vadd wrap", result, lanes);
    opcode = 4'h1;
    for (int i = 0; i < 16; i++) begin op_1[16*i +: 16] = 16'd2; op_2[16*i +: 16] = 16'd3; end
    #1;
    chk("vdot", result, 256'h60);
    opcode = 4'h2;
    op_1 = 256'd4;
    for (int i = 0; i < 16; i++) op_2[16*i +: 16] = 16'(i);
    #1;
    for (int i = 0; i < 16; i++) lanes[16*i +: 16] = 16'(4 * i);
    chk("smul", result, lanes);
    opcode = 4'h6; op_1 = 256'h1200; op_2 = 256'h0034;
    #1;
    chk("sll", result, 256'h1234);
    opcode = 4'h7; op_1 = 256'h0034; op_2 = 256'h0012;
    #1;
    chk("slh", result, 256'h1234);
    opcode = 4'h4; op_1 = {16'hAAAA, 224'd0, 16'hFFF0}; op_2 = 256'h0020;
    #1;
    chk("vld addr wrap", result, 256'h0010);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk1);
      rd_addr_1 = 3'($urandom); rd_addr_2 = 3'($urandom); wr_dst = 3'($urandom);
      v_wr_en = 1'($urandom); s_wr_en = 1'($urandom);
      v_wr_data = rand256(); s_wr_data = 16'($urandom);
      op_1 = rand256(); op_2 = rand256(); opcode = 4'($urandom_range(0, 15));
      if (n % 4 == 0) op_2 = {16{16'($urandom_range(0, 3))}};
      #1;
      chk_reads($sformatf("rnd%0d pre", n));
      chk($sformatf("rnd%0d alu op%0h", n, opcode), result, ref_alu(opcode, op_1, op_2));
      @(posedge Clk1); #1;
      if (v_wr_en) vmod[wr_dst] = v_wr_data;
      if (s_wr_en) smod[wr_dst] = s_wr_data;
      chk_reads($sformatf("rnd%0d post", n));
    end

    // Mid-sequence reset clears immediately and blocks writes.
    @(negedge Clk1);
    v_wr_en = 1'b0; s_wr_en = 1'b0;
    #2;
    Reset = 1'b0;
    clear_model();
    #1;
    for (int a = 0; a < 8; a++) begin
      rd_addr_1 = 3'(a); rd_addr_2 = 3'(7 - a);
      #0.1;
      chk_reads($sformatf("mid_rst a%0d", a));
    end
    wr_dst = 3'd5; v_wr_en = 1'b1; s_wr_en = 1'b1;
    v_wr_data = rand256(); s_wr_data = 16'h1357;
    rd_addr_1 = 3'd5;
    @(posedge Clk1); #1;
    chk_reads("wr_in_rst");
    v_wr_en = 1'b0; s_wr_en = 1'b0;
    opcode = 4'h8; op_1 = rand256(); op_2 = rand256();
    #1;
    chk("undef op8", result, '0);
    opcode = 4'hF;
    #1;
    chk("nop", result, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvp14_datapath.md
CVP14_DATAPATH -- requirements
Module: cvp14_datapath

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning registers per file (address width 3).
REQ-002 SHALL have parameter LANE_W, default 16, meaning lane and scalar width in bits.
REQ-003 SHALL have parameter LANES, default 16, meaning lanes per vector (vector width 256).
REQ-004 SHALL have port Clk1  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port rd_addr_1  input  3  meaning read address 1, shared by both files.
REQ-007 SHALL have port rd_addr_2  input  3  meaning read address 2, shared by both files.
REQ-008 SHALL have port wr_dst  input  3  meaning write address, shared by both files.
REQ-009 SHALL have port v_wr_en  input  1  meaning vector write enable.
REQ-010 SHALL have port v_wr_data  input  256  meaning vector write data.
REQ-011 SHALL have port s_wr_en  input  1  meaning scalar write enable.
REQ-012 SHALL have port s_wr_data  input  16  meaning scalar write data.
REQ-013 SHALL have ports v_data_1 and v_data_2  output  256 each  meaning vector read data for rd_addr_1 and rd_addr_2.
REQ-014 SHALL have ports s_data_1 and s_data_2  output  16 each  meaning scalar read data for rd_addr_1 and rd_addr_2.
REQ-015 SHALL have ports op_1 and op_2  input  256 each  meaning ALU operands.
REQ-016 SHALL have port opcode  input  4  meaning ALU function.
REQ-017 SHALL have port result  output  256  meaning ALU result.

Function
REQ-018 SHALL hold 8 x 256-bit vector registers; lane i occupies bits [16i+15:16i].
REQ-019 SHALL hold 8 x 16-bit scalar registers.
REQ-020 SHALL drive all read data combinationally from current register contents, with no write bypass; a write becomes visible only after the rising edge.
REQ-021 SHALL write v_wr_data to vector register wr_dst on a rising edge with v_wr_en=1, and s_wr_data to scalar register wr_dst on a rising edge with s_wr_en=1.
REQ-022 SHALL perform both writes in the same cycle when both enables are 1, since the files are independent.
REQ-023 SHALL compute result combinationally with zero latency, using unsigned modulo-2^16 arithmetic per lane with no saturation and no flags.
REQ-024 SHALL implement VADD 0000 as result lane i = op_1 lane i + op_2 lane i.
REQ-025 SHALL implement VDOT 0001 as result[15:0] = sum over 16 lanes of (op_1 lane i * op_2 lane i), each truncated to 16 bits; result[255:16]=0.
REQ-026 SHALL implement SMUL 0010 as result lane i = op_1[15:0] * op_2 lane i, truncated to 16 bits.
REQ-027 SHALL implement SST 0011, VLD 0100 and VST 0101 as address generation: result[15:0] = op_1[15:0] + op_2[15:0]; upper bits 0.
REQ-028 SHALL implement SLL 0110 as result[15:0] = {op_1[15:8], op_2[7:0]}; upper bits 0.
REQ-029 SHALL implement SLH 0111 as result[15:0] = {op_2[7:0], op_1[7:0]}; upper bits 0.
REQ-030 SHALL drive result=0 for NOP 1111 and for every undefined opcode.

Reset
REQ-031 SHALL clear all 16 registers to 0 asynchronously while Reset=0; writes are ignored while Reset=0.
REQ-032 SHALL, as a consequence, show all read outputs at 0 during and after reset until the first write; result has no state and depends only on op_1, op_2 and opcode.

Structure
REQ-033 SHALL place opcode constants, NREGS, LANE_W and LANES in shared package cvp14_pkg.
REQ-034 SHALL implement both files with one parameterized sub-module, cvp14_regfile (depth, width), instantiated twice.
REQ-035 SHALL implement the ALU as combinational logic in the top module.

Verification
REQ-036 Reset=0 then release; read all addresses -> all v_data and s_data equal 0.
REQ-037 v_wr_en=1, wr_dst=3, v_wr_data lane i = i; s_wr_en=1 with s_wr_data=16'hBEEF in the same cycle -> v_data_1 at addr 3 shows lanes 0..15; s_data_2 at addr 3 = BEEF; reads before the edge = 0.
REQ-038 VADD with all lanes 16'hFFFF + 16'h0002 -> every lane = 16'h0001 (wrap).
REQ-039 VDOT with op_1 lanes = 2 and op_2 lanes = 3 -> result[15:0] = 96 (0x0060), upper bits 0.
REQ-040 SMUL with op_1[15:0]=4 and op_2 lane i = i -> lane i = 4i; SLL with op_1=0x1200 and op_2=0x0034 -> 0x1234; SLH with op_1=0x0034 and op_2=0x0012 -> 0x1234.
REQ-041 Assert Reset=0 mid-sequence after writes -> registers read 0 immediately, without waiting for a clock edge; opcode 1000 -> result=0.
